// File: rtl/dc_commutator_if.sv
// Stream bundle between the radix-2 PE and the delay commutator.
// Latency: none (wires only).
// Backpressure: producer holds a beat while in_ready is low; outputs carry no ready.
// Ports: in_valid/in_ready/flush + in0..in3 toward the commutator,
//        out_valid + out0..out3 + busy from it.
interface dc_commutator_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic             out_valid;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic             busy;

  modport master (
    output in_valid, flush, in0, in1, in2, in3,
    input  in_ready, out_valid, out0, out1, out2, out3, busy
  );

  modport slave (
    input  in_valid, flush, in0, in1, in2, in3,
    output in_ready, out_valid, out0, out1, out2, out3, busy
  );
endinterface

// File: rtl/dc_commutator.sv
// Delay-commutator reorder stage: re-pairs samples D beats apart on pairs A=(in0,in2), B=(in1,in3).
// Latency: D internal beats plus one register cycle; first output on the beat after the D-th input.
// Backpressure: in_ready drops only while draining; stalls (no beat) freeze all state.
// Ports: clk, reset (sync, active-high), bus (slave modport of dc_commutator_if).
module dc_commutator #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic           clk,
  input  logic           reset,
  dc_commutator_if.slave bus
);
  localparam int D  = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         FILL_FULL  = CW'(D);
  localparam logic [DEPTH_LOG2-1:0] DRAIN_LAST = DEPTH_LOG2'(D - 1);

  typedef enum logic [1:0] {FILL, RUN, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         fill_q, fill_d;
  logic [CW-1:0]         phase_q, phase_d;
  logic [DEPTH_LOG2-1:0] drain_q, drain_d;

  // Per pair: bottom delay line and delay line for the selected "a" operand.
  // Index 0 is the newest entry, D-1 the one written D beats ago.
  logic [WIDTH-1:0] bdl_q [2][D];
  logic [WIDTH-1:0] bdl_d [2][D];
  logic [WIDTH-1:0] adl_q [2][D];
  logic [WIDTH-1:0] adl_d [2][D];
  logic [WIDTH-1:0] out_q [4];
  logic [WIDTH-1:0] out_d [4];
  logic             out_valid_q, out_valid_d;

  logic             in_ready;
  logic             accept;
  logic             beat;
  logic             sel;
  logic [WIDTH-1:0] top_in [2];
  logic [WIDTH-1:0] bot_in [2];
  logic [WIDTH-1:0] a_v [2];
  logic [WIDTH-1:0] b_v [2];

  assign in_ready = (state_q != DRAIN);
  assign accept   = bus.in_valid & in_ready;
  // Drain cycles always advance, feeding zeros to push the tail out.
  assign beat     = accept | (state_q == DRAIN);
  assign sel      = phase_q[DEPTH_LOG2];

  assign bus.in_ready  = in_ready;
  assign bus.busy      = (state_q != FILL) || (fill_q != '0);
  assign bus.out_valid = out_valid_q;
  assign bus.out0      = out_q[0];
  assign bus.out1      = out_q[1];
  assign bus.out2      = out_q[2];
  assign bus.out3      = out_q[3];

  always_comb begin
    top_in[0] = bus.in0;
    top_in[1] = bus.in1;
    bot_in[0] = bus.in2;
    bot_in[1] = bus.in3;
    if (state_q == DRAIN) begin
      top_in[0] = '0;
      top_in[1] = '0;
      bot_in[0] = '0;
      bot_in[1] = '0;
    end
  end

  // Datapath: swap network, delay-line shifting and output register load.
  always_comb begin
    bdl_d       = bdl_q;
    adl_d       = adl_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    for (int p = 0; p < 2; p++) begin
      a_v[p] = sel ? bdl_q[p][D-1] : top_in[p];
      b_v[p] = sel ? top_in[p]     : bdl_q[p][D-1];
    end
    if (beat) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = D - 1; i > 0; i--) begin
          bdl_d[p][i] = bdl_q[p][i-1];
          adl_d[p][i] = adl_q[p][i-1];
        end
        bdl_d[p][0] = bot_in[p];
        adl_d[p][0] = a_v[p];
      end
      // Only once D beats of the current frame are in the lines is the output meaningful.
      if (fill_q == FILL_FULL) begin
        for (int p = 0; p < 2; p++) begin
          out_d[p]   = adl_q[p][D-1];
          out_d[p+2] = b_v[p];
        end
        out_valid_d = 1'b1;
      end
    end
  end

  // Control FSM.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    phase_d = phase_q;
    drain_d = drain_q;
    if (beat) phase_d = phase_q + 1'b1;
    case (state_q)
      FILL: begin
        if (accept) fill_d = fill_q + 1'b1;
        // A flush before any sample arrived has nothing to drain.
        if (bus.flush && (fill_q != '0)) begin
          state_d = DRAIN;
          drain_d = '0;
        end else if (accept && (fill_q == FILL_FULL - 1'b1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // A beat presented with the flush is accepted on this edge before draining.
        if (bus.flush) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        // Fill keeps counting so a partially filled frame only emits once D beats are in.
        if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_LAST) begin
          state_d = FILL;
          fill_d  = '0;
          phase_d = '0;
          drain_d = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      fill_q      <= '0;
      phase_q     <= '0;
      drain_q     <= '0;
      out_valid_q <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < D; i++) begin
          bdl_q[p][i] <= '0;
          adl_q[p][i] <= '0;
        end
      end
      for (int l = 0; l < 4; l++) out_q[l] <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      phase_q     <= phase_d;
      drain_q     <= drain_d;
      out_valid_q <= out_valid_d;
      bdl_q       <= bdl_d;
      adl_q       <= adl_d;
      out_q       <= out_d;
    end
  end
endmodule

// File: tb/tb_dc_commutator.sv
// Bench for dc_commutator: D=2 table-driven scenarios plus D=8 randomized stream vs reference model.
module tb_dc_commutator;
  localparam int W  = 32;
  localparam int D8 = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dc_commutator_if #(.WIDTH(W)) b2 ();
  dc_commutator_if #(.WIDTH(W)) b8 ();

  dc_commutator #(.WIDTH(W), .DEPTH_LOG2(1)) u2 (.clk(clk), .reset(reset), .bus(b2));
  dc_commutator #(.WIDTH(W), .DEPTH_LOG2(3)) u8 (.clk(clk), .reset(reset), .bus(b8));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic vld; logic fl; int top; int bot;
    logic ev; int et; int eb; logic er; logic ebusy;
  } vec_t;
  vec_t tbl [12];

  int h2 [4];
  logic [31:0] h8 [4];

  // Reference history for the D=8 model, indexed by internal beat number since reset.
  logic [31:0] ht [2][128];
  logic [31:0] hb [2][128];
  bit          hs [128];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pb(input int x);
    return (x == 0) ? 0 : x + 200;
  endfunction

  task automatic drive2(input logic v, input logic f, input int t, input int b);
    b2.in_valid = v;
    b2.flush    = f;
    b2.in0      = t;
    b2.in2      = b;
    b2.in1      = pb(t);
    b2.in3      = pb(b);
  endtask

  task automatic drive8(input logic v, input logic f, input logic [31:0] x0, x1, x2, x3);
    b8.in_valid = v;
    b8.flush    = f;
    b8.in0      = x0;
    b8.in1      = x1;
    b8.in2      = x2;
    b8.in3      = x3;
  endtask

  task automatic check2(input string tag, input logic ev, input int et, input int eb,
                        input logic er, input logic ebusy);
    if (ev) begin
      h2[0] = et; h2[2] = eb; h2[1] = pb(et); h2[3] = pb(eb);
    end
    chk({tag, "_ov"},   32'(b2.out_valid), 32'(ev));
    chk({tag, "_o0"},   b2.out0, h2[0]);
    chk({tag, "_o2"},   b2.out2, h2[2]);
    chk({tag, "_o1"},   b2.out1, h2[1]);
    chk({tag, "_o3"},   b2.out3, h2[3]);
    chk({tag, "_rdy"},  32'(b2.in_ready), 32'(er));
    chk({tag, "_busy"}, 32'(b2.busy), 32'(ebusy));
  endtask

  task automatic run_table(input int nrows, input bit toggle);
    for (int i = 0; i < nrows; i++) begin
      drive2(tbl[i].vld, tbl[i].fl, tbl[i].top, tbl[i].bot);
      step();
      check2($sformatf("r%0d", i), tbl[i].ev, tbl[i].et, tbl[i].eb, tbl[i].er, tbl[i].ebusy);
      if (toggle && tbl[i].vld) begin
        drive2(1'b0, 1'b0, 999, 999);
        step();
        check2($sformatf("gap%0d", i), 1'b0, 0, 0, 1'b1, 1'b1);
      end
    end
    drive2(1'b0, 1'b0, 0, 0);
  endtask

  function automatic logic [31:0] a_of(input int p, input int j);
    if (j < 0) return '0;
    if (hs[j]) return (j - D8 < 0) ? '0 : hb[p][j-D8];
    return ht[p][j];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, seg0, acc, drain_left, cyc, nout, errs;
    bit flushed, beat, ev;
    logic v, f;
    logic [31:0] x [4];
    logic [31:0] e [4];
    logic [31:0] ins [$];
    int cnt [logic [31:0]];

    //          vld fl top bot  ev  et   eb  rdy busy
    tbl[0]  = '{1, 0, 1, 101,  0,  0,   0,   1, 1};
    tbl[1]  = '{1, 0, 2, 102,  0,  0,   0,   1, 1};
    tbl[2]  = '{1, 0, 3, 103,  1,  1,   3,   1, 1};
    tbl[3]  = '{1, 0, 4, 104,  1,  2,   4,   1, 1};
    tbl[4]  = '{1, 0, 5, 105,  1,  101, 103, 1, 1};
    tbl[5]  = '{1, 0, 6, 106,  1,  102, 104, 1, 1};
    tbl[6]  = '{1, 0, 7, 107,  1,  5,   7,   1, 1};
    tbl[7]  = '{1, 0, 8, 108,  1,  6,   8,   1, 1};
    tbl[8]  = '{0, 1, 0, 0,    0,  0,   0,   0, 1};
    tbl[9]  = '{0, 0, 0, 0,    1,  105, 107, 0, 1};
    tbl[10] = '{0, 0, 0, 0,    1,  106, 108, 1, 0};
    tbl[11] = '{0, 0, 0, 0,    0,  0,   0,   1, 0};

    reset = 1'b1;
    drive2(1'b0, 1'b0, 0, 0);
    drive8(1'b0, 1'b0, '0, '0, '0, '0);
    for (int l = 0; l < 4; l++) begin h2[l] = 0; h8[l] = '0; end
    step();
    step();
    check2("rst2", 1'b0, 0, 0, 1'b1, 1'b0);
    chk("rst8_ov",   32'(b8.out_valid), 32'd0);
    chk("rst8_o0",   b8.out0, 32'd0);
    chk("rst8_rdy",  32'(b8.in_ready), 32'd1);
    chk("rst8_busy", 32'(b8.busy), 32'd0);
    reset = 1'b0;

    // Continuous stream followed by a flush with in_valid low.
    run_table(12, 1'b0);
    // Same stream with in_valid toggling 1,0,1,0.
    run_table(12, 1'b1);

    // Reset mid-RUN, then the stream must replay identically.
    run_table(4, 1'b0);
    reset = 1'b1;
    drive2(1'b1, 1'b0, 77, 177);
    step();
    reset = 1'b0;
    drive2(1'b0, 1'b0, 0, 0);
    for (int l = 0; l < 4; l++) h2[l] = 0;
    check2("midrst", 1'b0, 0, 0, 1'b1, 1'b0);
    run_table(12, 1'b0);

    // Flush with nothing filled is ignored.
    drive2(1'b0, 1'b1, 0, 0);
    step();
    check2("fl0a", 1'b0, 0, 0, 1'b1, 1'b0);
    drive2(1'b0, 1'b0, 0, 0);
    step();
    check2("fl0b", 1'b0, 0, 0, 1'b1, 1'b0);

    // Flush together with a valid beat in RUN: beat taken, then D drain beats.
    run_table(6, 1'b0);
    drive2(1'b1, 1'b1, 7, 107);
    step();
    check2("flv0", 1'b1, 5, 7, 1'b0, 1'b1);
    drive2(1'b1, 1'b0, 55, 155);
    step();
    check2("flv1", 1'b1, 6, 0, 1'b0, 1'b1);
    drive2(1'b0, 1'b0, 0, 0);
    step();
    check2("flv2", 1'b1, 105, 107, 1'b1, 1'b0);
    step();
    check2("flv3", 1'b0, 0, 0, 1'b1, 1'b0);

    // Flush in FILL with one sample: only the last drain beat emits.
    drive2(1'b1, 1'b0, 1, 101);
    step();
    check2("ff0", 1'b0, 0, 0, 1'b1, 1'b1);
    drive2(1'b0, 1'b1, 0, 0);
    step();
    check2("ff1", 1'b0, 0, 0, 1'b0, 1'b1);
    drive2(1'b0, 1'b0, 0, 0);
    step();
    check2("ff2", 1'b0, 0, 0, 1'b0, 1'b1);
    step();
    check2("ff3", 1'b1, 1, 0, 1'b1, 1'b0);

    // Randomized D=8 stream of 64 accepted beats plus flush, against the reference model.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int l = 0; l < 4; l++) h8[l] = '0;
    g = 0; seg0 = 0; acc = 0; drain_left = 0; cyc = 0; nout = 0; flushed = 1'b0;
    while (1) begin
      if (acc < 64) begin
        v = ($urandom_range(0, 3) != 0); f = 1'b0;
      end else if (!flushed) begin
        v = 1'b0; f = 1'b1; flushed = 1'b1;
      end else if (drain_left > 0) begin
        v = 1'($urandom_range(0, 1)); f = 1'b0;
      end else begin
        break;
      end
      for (int l = 0; l < 4; l++) x[l] = {16'($urandom), 2'(l), 14'(acc)};
      drive8(v, f, x[0], x[1], x[2], x[3]);

      beat = (drain_left > 0) || v;
      ev = 1'b0;
      if (beat) begin
        for (int p = 0; p < 2; p++) begin
          ht[p][g] = (drain_left > 0) ? '0 : x[p];
          hb[p][g] = (drain_left > 0) ? '0 : x[p+2];
        end
        hs[g] = (((g - seg0) / D8) % 2) == 1;
        if (drain_left == 0) begin
          for (int l = 0; l < 4; l++) ins.push_back(x[l]);
          acc++;
        end
        if (g - seg0 >= D8) begin
          ev = 1'b1;
          for (int p = 0; p < 2; p++) begin
            e[p]   = a_of(p, g - D8);
            e[p+2] = hs[g] ? ht[p][g] : hb[p][g-D8];
          end
        end
        g++;
        if (drain_left > 0) begin
          drain_left--;
          if (drain_left == 0) seg0 = g;
        end
      end
      if (f) drain_left = D8;

      step();
      if (ev) for (int l = 0; l < 4; l++) h8[l] = e[l];
      chk("rnd_ov",   32'(b8.out_valid), 32'(ev));
      chk("rnd_o0",   b8.out0, h8[0]);
      chk("rnd_o1",   b8.out1, h8[1]);
      chk("rnd_o2",   b8.out2, h8[2]);
      chk("rnd_o3",   b8.out3, h8[3]);
      chk("rnd_rdy",  32'(b8.in_ready), 32'(drain_left == 0));
      chk("rnd_busy", 32'(b8.busy), 32'(!(drain_left == 0 && g == seg0)));
      if (b8.out_valid) begin
        nout += 4;
        if (cnt.exists(b8.out0)) cnt[b8.out0]++; else cnt[b8.out0] = 1;
        if (cnt.exists(b8.out1)) cnt[b8.out1]++; else cnt[b8.out1] = 1;
        if (cnt.exists(b8.out2)) cnt[b8.out2]++; else cnt[b8.out2] = 1;
        if (cnt.exists(b8.out3)) cnt[b8.out3]++; else cnt[b8.out3] = 1;
      end
      cyc++;
      if (cyc > 3000) begin
        chk("rnd_bound", 32'(cyc), 32'd3000);
        break;
      end
    end
    drive8(1'b0, 1'b0, '0, '0, '0, '0);

    errs = 0;
    foreach (ins[i]) if (!cnt.exists(ins[i]) || cnt[ins[i]] != 1) errs++;
    chk("rnd_once",  32'(errs), 32'd0);
    chk("rnd_nout",  32'(nout), 32'(ins.size()));
    chk("rnd_nin",   32'(ins.size()), 32'd256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dc_commutator.md
Name: dc_commutator

Overview:
- Delay-commutator reorder stage directly downstream of the radix-2 PE.
- Takes the PE's 4-lane output stream and splits it into two independent lane pairs: pair A = (in0 top, in2 bottom) and pair B = (in1 top, in3 bottom).
- Re-pairs samples that are DEPTH valid beats apart so the next PE sees matching butterfly operands.
- Supports valid-gated stalls and an explicit flush to drain the tail of a frame.

Parameters:
- WIDTH, 32: sample width per lane; matches the PE data width.
- DEPTH_LOG2, 2: log2 of the commutator delay. The internal constant D = 2**DEPTH_LOG2; DEPTH_LOG2 must be ≥1.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous reset, active-high.
- in_valid  in  1  input beat qualifier; a beat is accepted when in_valid & in_ready.
- in_ready  out  1  low only in DRAIN.
- flush  in  1  request to drain pending samples; single-cycle pulse.
- in0, in1, in2, in3  in  WIDTH each  lane inputs (from PE out0..out3).
- out_valid  out  1  output beat qualifier, one cycle per output beat.
- out0, out1, out2, out3  out  WIDTH each  reordered lanes. out0/out2 are pair A top/bottom; out1/out3 are pair B top/bottom.
- busy  out  1  high when state ≠ FILL or fill count ≠ 0.

Behaviour:
- Reset (synchronous, Reset=1 at edge):
  - all delay lines, out0..3 = 0; out_valid = 0.
  - state = FILL; fill count = 0; phase count = 0.
  - in_ready = 1 (combinational from state); busy = 0.
  - Reset mid-frame discards all pending data, with no output.
- Internal beat: occurs on an accepted input beat, or on each DRAIN cycle (with top/bottom inputs forced to 0). Nothing advances on any other cycle (stall); outputs hold and out_valid = 0.
- Per pair, on each internal beat k:
  - bd = bottom delayed by D beats.
  - sel = bit DEPTH_LOG2 of phase count (phase count is mod 2D, wraps 2D-1 → 0).
  - sel=0: a = top, b = bd. sel=1: a = bd, b = top.
  - Output top = a delayed by D beats; output bottom = b.
  - Both pairs share sel and the counters.
- Output register: out0..3 load on an internal beat when fill count == D (RUN or DRAIN); out_valid <= 1 on the same edge, else 0.
  - Latency: first output edge is the beat after the D-th accepted input; per-beat pipeline latency is D beats plus 1 cycle.
- FSM:
  - FILL: fill count increments per internal beat; it goes to RUN on the beat that makes it D. flush is ignored if fill count = 0; if fill count > 0, go to DRAIN.
  - RUN: flush with in_valid=0 → DRAIN. If flush and in_valid are both high, the beat is accepted first and DRAIN is entered next cycle; flush is registered as pending.
  - DRAIN: exactly D internal zero beats, in_ready=0, in_valid ignored. Then go to FILL with fill count = 0 and phase count = 0. Delay lines are not cleared; they are overwritten.
    - Entered from FILL with fill count f < D: out_valid is asserted only on the beats where fill count reaches D. Fill keeps counting through drain beats, so max(0, f) ... effectively the last f beats produce output; the earlier leading beats do not.
- Arithmetic: none; pure data movement. Widths are preserved exactly (no truncation or sign change).
- Phase count wrap and the FILL→RUN transition on the same beat are legal and independent.

Test Plan:
- DEPTH_LOG2=1 (D=2), continuous in_valid:
  - pair A tops a0..a7 = 1..8, bottoms b0..b7 = 101..108.
  - Required out0/out2 per valid beat: (1,3), (2,4), (101,103), (102,104), (5,7), (6,8).
  - out_valid first rises 1 cycle after the 2nd accepted beat.
  - Identical check on pair B with offset values.
- Same stream with in_valid toggling 1,0,1,0: the output sequence is identical, out_valid only follows accepted beats, and data holds during gaps.
- After 8 beats (D=2), pulse flush with in_valid=0:
  - in_ready low for exactly 2 cycles; 2 more out_valid beats emitted: out0/out2 = (105,107), (106,108).
  - Then in_ready=1, busy=0.
- Assert Reset for 1 cycle mid-RUN: next cycle out0..3 = 0, out_valid = 0, in_ready = 1. A fresh stream reproduces scenario 1 exactly.
- flush with fill count 0 → no state change, busy stays 0. flush and in_valid together in RUN → the beat is accepted, then drain of D beats.
- DEPTH_LOG2=3, random 64-beat stream plus flush: scoreboard against a reference model; every input sample appears exactly once on the outputs, in order-matched pairs.
